mul_share_sched: RTL and testbench
==================================

Name: mul_share_sched

Overview:
- Round-robin scheduler that shares the serial-load 16x16 multiplier between two requesters.
- Accepts parallel operands, shifts them MSB-first onto the multiplier's serial inputs and pulses its latch gate.
- Waits a settle interval, captures the 32-bit product and returns it tagged with the requester id.
- Sits between the requester logic and the multiplier datapath; it is the only driver of ser_a, ser_b and latch_gate.

Parameters:
- WIDTH, 16: operand width. Equals the multiplier shift-register depth.
- SETTLE_CYC, 2: cycles between latch deassertion and product capture. Minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept, one-hot or zero
- req0_a, req0_b  in  WIDTH each  requester 0 operands
- req1_a, req1_b  in  WIDTH each  requester 1 operands
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  1  requester that owns rsp_data
- rsp_data  out  2*WIDTH  registered product
- ser_a, ser_b  out  1 each  serial operand bits to multiplier shift registers
- latch_gate  out  1  multiplier operand latch enable
- mul_result  in  2*WIDTH  combinational product from multiplier
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - All outputs 0: rsp_valid, rsp_id, rsp_data, ser_a, ser_b, latch_gate, req_ready, busy.
- States: IDLE -> SHIFT -> LATCH -> SETTLE -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational from req_valid and last_grant.
  - Only one requester valid: it is granted.
  - Both valid: the one not equal to last_grant is granted.
  - Accept = req_valid[i] & req_ready[i]. On accept, capture the operands into internal shift registers, record the id, set last_grant=i, and go to SHIFT with count=0.
- SHIFT:
  - Lasts exactly WIDTH cycles. ser_a/ser_b are registered and present bit WIDTH-1-count of the operands (MSB first).
  - After WIDTH clock edges the multiplier shift registers hold the operands exactly.
  - Go to LATCH when count=WIDTH-1. req_ready=0.
- LATCH: latch_gate=1 for exactly one cycle. ser_a/ser_b held at 0.
- SETTLE:
  - latch_gate=0; counter runs SETTLE_CYC cycles.
  - On the last SETTLE cycle's edge, rsp_data<=mul_result, rsp_id<=granted id, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are stable until the handshake.
  - On rsp_ready=1, go to IDLE and clear rsp_valid at that edge.
  - No new acceptance in the same cycle; the earliest new accept is the following cycle.
- Latency, defaults: accept edge E0, SHIFT ends at E16, LATCH ends at E17, capture at E19. rsp_valid is high in the cycle after E19, i.e. 19 clocks after accept. General form: WIDTH+1+SETTLE_CYC.
- Requests arriving while busy are stalled (req_ready=0); req_valid is held by the requester.
- Reset mid-operation: immediate IDLE with all outputs 0. An in-flight request is dropped with no response. latch_gate never glitches high during reset.
- latch_gate is a registered output, never combinational.

Optional Feature:
- Macro: MUL_REUSE_EN.
- When defined:
  - Store the last latched operand pair and a cache_valid flag; cache_valid=0 on reset.
  - On accept with operands equal to the stored pair and cache_valid=1, skip SHIFT, LATCH and SETTLE. Go directly to RESP, capturing rsp_data<=mul_result at the accept edge. The multiplier latch still holds those operands.
  - ser_a, ser_b and latch_gate stay 0 for that request. rsp_valid is high 1 cycle after accept.
  - cache_valid is set on every LATCH cycle.
- When not defined: every request runs the full sequence.

Test Plan:
- Single request 0, a=0x1234, b=0x0010, mul_result modelled by a behavioural multiplier -> ser_a bit sequence 0001001000110100 over 16 cycles, one latch_gate pulse, rsp_valid after 19 clocks, rsp_data=0x00012340, rsp_id=0.
- Both requesters valid continuously, operands (3,5) and (0xFFFF,0xFFFF), rsp_ready=1 -> grants alternate 0,1,0,1. Products 0x0000000F and 0xFFFE0001 with matching rsp_id.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout; the new request is accepted the cycle after the handshake.
- rst asserted mid-SHIFT at count=7 -> all outputs 0 asynchronously and no response. After release, a request (2,3) returns 6 with full latency.
- SETTLE_CYC=1 build -> capture 18 clocks after accept. Boundary a=0, b=0xFFFF -> rsp_data=0.
- MUL_REUSE_EN: (7,9) twice -> second response 1 cycle after accept, no latch_gate pulse, rsp_data=63. Then (7,10) -> full sequence, 70.

Source files
------------

// File: rtl/mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_sched
// Purpose  : Round-robin scheduler sharing one serial-load multiplier between
//            two requesters. Optional operand reuse cache: MUL_REUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_sched #(
    parameter int WIDTH      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic                 ser_a,
    output logic                 ser_b,
    output logic                 latch_gate,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 busy
);

    localparam int CMAX = (WIDTH > SETTLE_CYC) ? WIDTH : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_LATCH  = 3'd2,
        S_SETTLE = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              last_grant_q;
    logic              id_q;
    logic [WIDTH-1:0]  sh_a_q;
    logic [WIDTH-1:0]  sh_b_q;

    logic              w_gid;
    logic              w_accept;
    logic              w_hit;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;

`ifdef MUL_REUSE_EN
    logic              cache_valid_q;
    logic [WIDTH-1:0]  cache_a_q;
    logic [WIDTH-1:0]  cache_b_q;
`endif

    always_comb begin
        w_gid = 1'b0;
        case (req_valid)
            2'b10:   w_gid = 1'b1;
            2'b11:   w_gid = ~last_grant_q;
            default: w_gid = 1'b0;
        endcase
        req_ready = 2'b00;
        if (!rst && state_q == S_IDLE && req_valid != 2'b00)
            req_ready = w_gid ? 2'b10 : 2'b01;
    end

    assign w_accept = |(req_valid & req_ready);
    assign w_sel_a  = w_gid ? req1_a : req0_a;
    assign w_sel_b  = w_gid ? req1_b : req0_b;

`ifdef MUL_REUSE_EN
    assign w_hit = cache_valid_q && (w_sel_a == cache_a_q) && (w_sel_b == cache_b_q);
`else
    assign w_hit = 1'b0;
`endif

    // The operand registers rotate rather than shift, so after WIDTH-1
    // rotations in SHIFT they hold the original operands again for the cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            sh_a_q       <= '0;
            sh_b_q       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= '0;
            ser_a        <= 1'b0;
            ser_b        <= 1'b0;
            latch_gate   <= 1'b0;
            busy         <= 1'b0;
`ifdef MUL_REUSE_EN
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        id_q         <= w_gid;
                        last_grant_q <= w_gid;
                        busy         <= 1'b1;
                        cnt_q        <= '0;
                        if (w_hit) begin
                            rsp_data  <= mul_result;
                            rsp_id    <= w_gid;
                            rsp_valid <= 1'b1;
                            state_q   <= S_RESP;
                        end else begin
                            ser_a   <= w_sel_a[WIDTH-1];
                            ser_b   <= w_sel_b[WIDTH-1];
                            sh_a_q  <= {w_sel_a[WIDTH-2:0], w_sel_a[WIDTH-1]};
                            sh_b_q  <= {w_sel_b[WIDTH-2:0], w_sel_b[WIDTH-1]};
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        ser_a      <= 1'b0;
                        ser_b      <= 1'b0;
                        latch_gate <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_LATCH;
                    end else begin
                        ser_a  <= sh_a_q[WIDTH-1];
                        ser_b  <= sh_b_q[WIDTH-1];
                        sh_a_q <= {sh_a_q[WIDTH-2:0], sh_a_q[WIDTH-1]};
                        sh_b_q <= {sh_b_q[WIDTH-2:0], sh_b_q[WIDTH-1]};
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_LATCH: begin
                    latch_gate <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= S_SETTLE;
`ifdef MUL_REUSE_EN
                    cache_valid_q <= 1'b1;
                    cache_a_q     <= sh_a_q;
                    cache_b_q     <= sh_b_q;
`endif
                end
                S_SETTLE: begin
                    if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                        rsp_data  <= mul_result;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_sched
// Purpose  : Randomized self-checking bench with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_sched;

    localparam int W   = 16;
    localparam int S   = 2;
    localparam int LAT = W + 1 + S;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [2*W-1:0] rsp_data;
    logic           ser_a, ser_b, latch_gate, busy;
    logic [2*W-1:0] mul_result;

    always #5 clk = ~clk;

    mul_share_sched #(.WIDTH(W), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .ser_a(ser_a), .ser_b(ser_b),
        .latch_gate(latch_gate), .mul_result(mul_result), .busy(busy)
    );

    // Behavioural serial-load multiplier: shift registers plus operand latch.
    logic [W-1:0] msh_a = '0, msh_b = '0, mlat_a = '0, mlat_b = '0;
    always @(posedge clk) begin
        msh_a <= {msh_a[W-2:0], ser_a};
        msh_b <= {msh_b[W-2:0], ser_b};
        if (latch_gate) begin
            mlat_a <= msh_a;
            mlat_b <= msh_b;
        end
    end
    assign mul_result = (2*W)'(mlat_a) * (2*W)'(mlat_b);

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference state
    bit             m_busy, m_hit, m_last, m_id, m_rid, m_cv;
    int             m_k, m_lat;
    logic [W-1:0]   m_a, m_b, m_ca, m_cb;
    logic [2*W-1:0] m_data;
    logic [1:0]     m_grant;
    logic [2*W-1:0] q0[$], q1[$];
    int             stall_left = 0;
    bit             rand_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_hit = 0; m_last = 1; m_id = 0; m_rid = 0; m_cv = 0;
        m_k = 0; m_lat = LAT; m_a = '0; m_b = '0; m_ca = '0; m_cb = '0;
        m_data = '0; m_grant = 2'b00;
    endtask

    // Advance the model across the clock edge that just occurred.
    task automatic step_model();
        logic [2*W-1:0] e;
        if (m_busy) begin
            if (m_k >= m_lat && rsp_ready) begin
                m_busy = 0;
            end else begin
                m_k++;
                if (!m_hit && m_k == W) begin
                    m_cv = 1; m_ca = m_a; m_cb = m_b;
                end
                if (m_k == m_lat) begin
                    m_data = (2*W)'(m_a) * (2*W)'(m_b);
                    m_rid  = m_id;
                end
            end
        end else if (m_grant != 2'b00) begin
            m_id = m_grant[1];
            if (m_id) e = q1.pop_front(); else e = q0.pop_front();
            {m_a, m_b} = e;
            m_last = m_id;
            m_busy = 1;
            m_k    = 0;
`ifdef MUL_REUSE_EN
            m_hit = m_cv && (m_a == m_ca) && (m_b == m_cb);
`else
            m_hit = 0;
`endif
            m_lat = m_hit ? 0 : LAT;
            if (m_hit) begin
                m_data = (2*W)'(m_a) * (2*W)'(m_b);
                m_rid  = m_id;
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_rv, exp_lg, exp_sa, exp_sb;
        exp_rv = m_busy && (m_k >= m_lat);
        exp_lg = m_busy && !m_hit && (m_k == W);
        exp_sa = 1'b0;
        exp_sb = 1'b0;
        if (m_busy && !m_hit && m_k < W) begin
            exp_sa = m_a[W-1-m_k];
            exp_sb = m_b[W-1-m_k];
        end
        check_eq("rsp_valid", rsp_valid, exp_rv);
        check_eq("rsp_data", rsp_data, m_data);
        check_eq("rsp_id", rsp_id, m_rid);
        check_eq("busy", busy, m_busy);
        check_eq("latch_gate", latch_gate, exp_lg);
        check_eq("ser_a", ser_a, exp_sa);
        check_eq("ser_b", ser_b, exp_sb);
    endtask

    task automatic drive_and_grant();
        logic [2*W-1:0] e;
        req_valid = {q1.size() != 0, q0.size() != 0};
        e = (q0.size() != 0) ? q0[0] : (2*W)'($urandom);
        {req0_a, req0_b} = e;
        e = (q1.size() != 0) ? q1[0] : (2*W)'($urandom);
        {req1_a, req1_b} = e;
        if (stall_left > 0) begin
            rsp_ready = 1'b0;
            if (m_busy && m_k >= m_lat) stall_left--;
        end else begin
            rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        m_grant = 2'b00;
        if (!m_busy) begin
            case (req_valid)
                2'b01:   m_grant = 2'b01;
                2'b10:   m_grant = 2'b10;
                2'b11:   m_grant = m_last ? 2'b01 : 2'b10;
                default: m_grant = 2'b00;
            endcase
        end
        check_eq("req_ready", req_ready, m_grant);
    endtask

    task automatic cycle();
        @(negedge clk);
        step_model();
        check_outputs();
        drive_and_grant();
    endtask

    task automatic run_idle(input int max_cyc);
        int i = 0;
        while ((m_busy || q0.size() != 0 || q1.size() != 0) && i < max_cyc) begin
            cycle();
            i++;
        end
        check_eq("drain_timeout", {m_busy, q0.size() != 0, q1.size() != 0}, 0);
    endtask

    function automatic logic [2*W-1:0] pr(input int a, input int b);
        return {W'(a), W'(b)};
    endfunction

    initial begin
        logic [2*W-1:0] last_pair;
        int guard;
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check_eq("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        drive_and_grant();

        // Arbitration with both requesters continuously valid
        q0.push_back(pr(3, 5));          q0.push_back(pr(3, 5));
        q1.push_back(pr(16'hFFFF, 16'hFFFF)); q1.push_back(pr(16'hFFFF, 16'hFFFF));
        run_idle(200);

        q0.push_back(pr(16'h1234, 16'h0010));
        run_idle(100);

        // Consumer stall with another request pending
        stall_left = 10;
        q0.push_back(pr(16'h00AA, 16'h0055));
        q1.push_back(pr(16'h0101, 16'h0202));
        run_idle(300);

        // Asynchronous reset in the middle of SHIFT
        q0.push_back(pr(16'hABCD, 16'h1111));
        guard = 0;
        while (!(m_busy && m_k == 7) && guard < 50) begin
            cycle();
            guard++;
        end
        check_eq("reach_shift7", guard < 50, 1);
        q1.push_back(pr(2, 3));
        drive_and_grant();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check_eq("rst_async_req_ready", req_ready, 0);
        repeat (2) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b0;
        drive_and_grant();
        run_idle(100);

        // Boundary operands
        q0.push_back(pr(0, 16'hFFFF));
        q1.push_back(pr(16'hFFFF, 1));
        run_idle(200);

        // Repeated operands exercise the reuse path when enabled
        q0.push_back(pr(7, 9));
        run_idle(100);
        q0.push_back(pr(7, 9));
        run_idle(100);
        q0.push_back(pr(7, 10));
        run_idle(100);

        // Randomized traffic
        rand_ready = 1'b1;
        last_pair = pr(1, 1);
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < 2; r++) begin
                logic [2*W-1:0] e;
                int sel;
                if ($urandom_range(0, 3) == 0 && (r == 0 ? q0.size() : q1.size()) < 2) begin
                    sel = $urandom_range(0, 9);
                    if (sel < 3)       e = last_pair;
                    else if (sel == 3) e = pr(0, $urandom);
                    else if (sel == 4) e = pr(16'hFFFF, 16'hFFFF);
                    else               e = (2*W)'($urandom);
                    last_pair = e;
                    if (r == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
            cycle();
        end
        run_idle(500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
